// File: rtl/tri_raster_collector.sv
// rtl/tri_raster_collector.sv - capture rasterizer point stream into an N x N bitmap and replay it row by row
//
// Purpose: collects (xo, yo) points while the rasterizer is busy, then, on the
// falling edge of busy, presents the bitmap one row per row_valid/row_ready
// handshake, pulses frame_done after the last row and clears for the next frame.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   busy                    rasterizer busy; 1->0 ends the frame
//   po, xo, yo              point stream, one point per cycle, no backpressure
//   row_valid, row_ready    drained-row handshake
//   row_idx, row_mask       y index of the presented row and its pixel mask (bit i = x i)
//   pix_cnt                 distinct pixels captured in the current frame
//   frame_done              one-cycle pulse after the last row is accepted
//   dup_err, lost_err       sticky: repeated point / point dropped while draining
//
// Optional feature macro: TRI_COLLECT_BBOX_EN adds bb_xmin/bb_xmax/bb_ymin/bb_ymax
// and bb_valid, a bounding box over the captured points.

module tri_raster_collector #(
    parameter int COORD_W = 3,
    localparam int N      = 2 ** COORD_W,
    localparam int CNT_W  = 2 * COORD_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               busy,
    input  logic               po,
    input  logic [COORD_W-1:0] xo,
    input  logic [COORD_W-1:0] yo,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [COORD_W-1:0] row_idx,
    output logic [N-1:0]       row_mask,
    output logic [CNT_W-1:0]   pix_cnt,
    output logic               frame_done,
    output logic               dup_err,
    output logic               lost_err
`ifdef TRI_COLLECT_BBOX_EN
    ,
    output logic [COORD_W-1:0] bb_xmin,
    output logic [COORD_W-1:0] bb_xmax,
    output logic [COORD_W-1:0] bb_ymin,
    output logic [COORD_W-1:0] bb_ymax,
    output logic               bb_valid
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic             busy_q;
    logic [N*N-1:0]   bitmap;   // bit index {y, x}: row y occupies bits [y*N +: N]

    logic             capture;
    logic             hit;
    logic             new_pt;
    logic [CNT_W-1:0] cnt_next;

    // Points are accepted in IDLE and COLLECT only; later ones are counted as lost.
    assign capture  = po && (state == S_IDLE || state == S_COLLECT);
    assign hit      = bitmap[{yo, xo}];
    assign new_pt   = capture && !hit;
    assign cnt_next = pix_cnt + CNT_W'(new_pt);

    assign row_mask = bitmap[{row_idx, {COORD_W{1'b0}}} +: N];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy_q     <= 1'b0;
            bitmap     <= '0;
            row_valid  <= 1'b0;
            row_idx    <= '0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            dup_err    <= 1'b0;
            lost_err   <= 1'b0;
`ifdef TRI_COLLECT_BBOX_EN
            bb_xmin    <= COORD_W'(N - 1);
            bb_xmax    <= '0;
            bb_ymin    <= COORD_W'(N - 1);
            bb_ymax    <= '0;
            bb_valid   <= 1'b0;
`endif
        end else begin
            busy_q <= busy;

            if (capture) begin
                bitmap[{yo, xo}] <= 1'b1;
                if (hit) begin
                    dup_err <= 1'b1;
                end else begin
                    pix_cnt <= cnt_next;
`ifdef TRI_COLLECT_BBOX_EN
                    if (xo < bb_xmin) bb_xmin <= xo;
                    if (xo > bb_xmax) bb_xmax <= xo;
                    if (yo < bb_ymin) bb_ymin <= yo;
                    if (yo > bb_ymax) bb_ymax <= yo;
`endif
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (busy || po) state <= S_COLLECT;
                end
                S_COLLECT: begin
                    // A point in the same cycle as the busy fall is still in cnt_next.
                    if (!busy && busy_q) begin
                        state     <= S_DRAIN;
                        row_valid <= 1'b1;
                        row_idx   <= '0;
`ifdef TRI_COLLECT_BBOX_EN
                        bb_valid  <= (cnt_next != '0);
`endif
                    end
                end
                S_DRAIN: begin
                    if (po) lost_err <= 1'b1;
                    if (row_ready) begin
                        if (row_idx == COORD_W'(N - 1)) begin
                            state      <= S_DONE;
                            row_valid  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            row_idx <= row_idx + COORD_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (po) lost_err <= 1'b1;
                    state      <= S_IDLE;
                    frame_done <= 1'b0;
                    bitmap     <= '0;
                    pix_cnt    <= '0;
                    row_idx    <= '0;
`ifdef TRI_COLLECT_BBOX_EN
                    bb_xmin    <= COORD_W'(N - 1);
                    bb_xmax    <= '0;
                    bb_ymin    <= COORD_W'(N - 1);
                    bb_ymax    <= '0;
                    bb_valid   <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule
